// File: rtl/ddr5_cmd_scheduler.sv
// DDR5 command scheduler: an in-order request FIFO feeds an open-page
// PRE/ACT/CAS sequencer that issues two-slot commands on even clk cycles.
module ddr5_cmd_scheduler #(
  parameter int QDEPTH = 16,
  parameter int BG_W   = 3,
  parameter int BA_W   = 2,
  parameter int ROW_W  = 16,
  parameter int COL_W  = 10,
  parameter int T_RCD  = 39,
  parameter int T_RP   = 39,
  parameter int T_RAS  = 76,
  parameter int T_RTP  = 18,
  parameter int T_CWD  = 38,
  parameter int T_WR   = 30,
  parameter int BURST  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_opn,
  input  logic [BG_W-1:0]  req_bg,
  input  logic [BA_W-1:0]  req_bank,
  input  logic [ROW_W-1:0] req_row,
  input  logic [COL_W-1:0] req_col,
  output logic             cmd_valid,
  output logic [2:0]       cmd_type,
  output logic [BG_W-1:0]  cmd_bg,
  output logic [BA_W-1:0]  cmd_bank,
  output logic [ROW_W-1:0] cmd_addr,
  output logic             busy
);
  localparam int NBANK = 1 << (BG_W + BA_W);
  localparam int BI_W  = BG_W + BA_W;
  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);

  localparam logic [31:0] RP_GAP  = 32'(T_RP);
  localparam logic [31:0] RCD_GAP = 32'(T_RCD);
  localparam logic [31:0] RAS_GAP = 32'(T_RAS);
  localparam logic [31:0] RD_GAP  = 32'(T_RTP);
  localparam logic [31:0] WR_GAP  = 32'(T_CWD + BURST + T_WR);

  localparam logic [2:0] CMD_NOP  = 3'd0;
  localparam logic [2:0] CMD_ACT0 = 3'd1;
  localparam logic [2:0] CMD_ACT1 = 3'd2;
  localparam logic [2:0] CMD_RD0  = 3'd3;
  localparam logic [2:0] CMD_RD1  = 3'd4;
  localparam logic [2:0] CMD_WR0  = 3'd5;
  localparam logic [2:0] CMD_WR1  = 3'd6;
  localparam logic [2:0] CMD_PRE  = 3'd7;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ACT0, S_ACT1, S_CAS0, S_CAS1} state_t;

  typedef struct packed {
    logic             wr;
    logic [BG_W-1:0]  bg;
    logic [BA_W-1:0]  bank;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } entry_t;

  entry_t           mem [QDEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] count;
  logic             active;
  logic [31:0]      cyc, act_cycle, cas_ready, cas_lim;
  logic             bank_open [NBANK];
  logic [ROW_W-1:0] bank_row  [NBANK];
  logic [31:0]      bank_epre [NBANK];
  logic [31:0]      bank_eact [NBANK];
  state_t           state, state_next;
  logic             go, push, pop, even;
  entry_t           head;
  logic [BI_W-1:0]  hb;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // active delays req_ready and the cycle counter by one edge after reset release
  assign req_ready = active && (count < CNT_W'(QDEPTH));
  assign push      = req_valid && req_ready && (req_opn != 2'd3);
  assign pop       = (state == S_CAS1) && go;
  assign head      = mem[rptr];
  assign hb        = {head.bg, head.bank};
  assign even      = ~cyc[0];
  assign cas_lim   = cyc + (head.wr ? WR_GAP : RD_GAP);
  assign busy      = (count != '0) || (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      active <= 1'b0;
      cyc    <= '0;
    end else begin
      active <= 1'b1;
      if (active) cyc <= cyc + 32'd1;
      if (push) wptr <= ptr_inc(wptr);
      if (pop) rptr <= ptr_inc(rptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{wr: (req_opn == 2'd1), bg: req_bg, bank: req_bank,
                              row: req_row, col: req_col};
  end

  // Bank bookkeeping runs off the same issue strobe that drives cmd_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_cycle <= '0;
      cas_ready <= '0;
      for (int i = 0; i < NBANK; i++) begin
        bank_open[i] <= 1'b0;
        bank_row[i]  <= '0;
        bank_epre[i] <= '0;
        bank_eact[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: if (count != '0) cas_ready <= '0;
        S_PRE: if (go) begin
          bank_open[hb] <= 1'b0;
          bank_eact[hb] <= cyc + RP_GAP;
        end
        S_ACT0: if (go) begin
          act_cycle <= cyc;
          cas_ready <= cyc + RCD_GAP;
        end
        S_ACT1: if (go) begin
          bank_open[hb] <= 1'b1;
          bank_row[hb]  <= head.row;
          bank_epre[hb] <= act_cycle + RAS_GAP;
        end
        S_CAS0: if (go) bank_epre[hb] <= (bank_epre[hb] > cas_lim) ? bank_epre[hb] : cas_lim;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    go         = 1'b0;
    cmd_type   = CMD_NOP;
    cmd_addr   = '0;
    case (state)
      S_IDLE: if (count != '0) begin
        if (!bank_open[hb])                state_next = S_ACT0;
        else if (bank_row[hb] == head.row) state_next = S_CAS0;
        else                               state_next = S_PRE;
      end
      S_PRE: begin
        go = even && (cyc >= bank_epre[hb]);
        if (go) begin
          cmd_type   = CMD_PRE;
          state_next = S_ACT0;
        end
      end
      S_ACT0: begin
        go = even && (cyc >= bank_eact[hb]);
        if (go) begin
          cmd_type   = CMD_ACT0;
          cmd_addr   = head.row;
          state_next = S_ACT1;
        end
      end
      S_ACT1: begin
        go = even;
        if (go) begin
          cmd_type   = CMD_ACT1;
          cmd_addr   = head.row;
          state_next = S_CAS0;
        end
      end
      S_CAS0: begin
        go = even && (cyc >= cas_ready);
        if (go) begin
          cmd_type   = head.wr ? CMD_WR0 : CMD_RD0;
          cmd_addr   = ROW_W'(head.col);
          state_next = S_CAS1;
        end
      end
      S_CAS1: begin
        go = even;
        if (go) begin
          cmd_type   = head.wr ? CMD_WR1 : CMD_RD1;
          cmd_addr   = ROW_W'(head.col);
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign cmd_valid = go;
  assign cmd_bg    = go ? head.bg : '0;
  assign cmd_bank  = go ? head.bank : '0;

endmodule
